// File: rtl/lagd_l1_j_reader.sv
// Streams num_words wide words from the memory direct port into a small registered FIFO
// feeding the Ising core; request credits keep outstanding reads plus buffered words within FifoDepth.
//
// state | meaning
// IDLE  | waiting for start_i; a zero-length start only pulses done_o
// FETCH | issuing read requests while credits allow
// DRAIN | all requests issued; waiting for the last_o beat to be accepted
module lagd_l1_j_reader #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 256,
  parameter int unsigned CntWidth  = 16,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [CntWidth-1:0]  num_words_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 last_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned OccW = $clog2(FifoDepth + 1);
  localparam logic [AddrWidth-1:0] AddrStep = AddrWidth'(DataWidth / 8);
  localparam logic [PtrW-1:0]      PtrMax   = PtrW'(FifoDepth - 1);
  localparam logic [OccW-1:0]      OccFull  = OccW'(FifoDepth);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e               state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [CntWidth-1:0]  num_q, issued_q, received_q;
  logic [OccW-1:0]      outstanding_q, count_q;
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic                 done_q;

  logic [DataWidth-1:0] fifo_data_q [FifoDepth];
  logic                 fifo_last_q [FifoDepth];

  logic          handshake, push, pop;
  logic [OccW:0] credit_used;
  logic [PtrW-1:0] wptr_d, rptr_d;

  assign credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
  // Credit sum only grows on a handshake, so a raised request cannot drop before its grant.
  assign mem_req_o   = (state_q == FETCH) && (issued_q < num_q)
                       && (credit_used < {1'b0, OccFull});
  assign handshake   = mem_req_o && mem_gnt_i;
  // Late responses after a mid-transfer reset find no outstanding credit and are dropped.
  assign push        = mem_rvalid_i && (state_q != IDLE) && (outstanding_q != '0);
  assign pop         = valid_o && ready_i;
  assign wptr_d      = (wptr_q == PtrMax) ? '0 : wptr_q + PtrW'(1);
  assign rptr_d      = (rptr_q == PtrMax) ? '0 : rptr_q + PtrW'(1);

  assign mem_addr_o = addr_q;
  assign mem_we_o   = 1'b0;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign valid_o    = (count_q != '0);
  assign data_o     = fifo_data_q[rptr_q];
  assign last_o     = valid_o && fifo_last_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      num_q         <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (num_words_i != '0) begin
              addr_q     <= base_addr_i;
              num_q      <= num_words_i;
              issued_q   <= '0;
              received_q <= '0;
              state_q    <= FETCH;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (handshake) begin
            addr_q   <= addr_q + AddrStep;
            issued_q <= issued_q + CntWidth'(1);
            if (issued_q + CntWidth'(1) == num_q) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && last_o) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (handshake && !push)      outstanding_q <= outstanding_q + OccW'(1);
      else if (!handshake && push) outstanding_q <= outstanding_q - OccW'(1);

      if (push && !pop)      count_q <= count_q + OccW'(1);
      else if (pop && !push) count_q <= count_q - OccW'(1);

      if (push) begin
        wptr_q     <= wptr_d;
        received_q <= received_q + CntWidth'(1);
      end
      if (pop) rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wptr_q] <= mem_rdata_i;
      fifo_last_q[wptr_q] <= (received_q == num_q - CntWidth'(1));
    end
  end

  // A response with no credit behind it, or into a full FIFO with no pop, means a broken memory port.
  assert property (@(posedge clk_i) disable iff (rst_i)
    mem_rvalid_i |-> ((outstanding_q != '0) && !((count_q == OccFull) && !pop)));

endmodule

// File: tb/tb_lagd_l1_j_reader.sv
// Directed bench for lagd_l1_j_reader: a latency-1/2 memory model, handshake/pop logs,
// and hand-computed addresses, ordering, last flags and done timing.
module tb_lagd_l1_j_reader;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [63:0]  base_addr_i;
  logic [15:0]  num_words_i;
  logic         busy_o, done_o, mem_req_o, mem_gnt_i, mem_we_o;
  logic [63:0]  mem_addr_o;
  logic         mem_rvalid_i;
  logic [255:0] mem_rdata_i;
  logic [255:0] data_o;
  logic         last_o, valid_o, ready_i;

  lagd_l1_j_reader dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .num_words_i(num_words_i),
    .busy_o(busy_o), .done_o(done_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .data_o(data_o), .last_o(last_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [255:0] pat(input logic [63:0] a);
    return {a ^ 64'h0123_4567_89AB_CDEF, ~a, a, a + 64'd7};
  endfunction

  // memory model: in-order, latency 1 or 2 after grant
  int           lat = 1;
  logic         rv1, rv2;
  logic [255:0] rd1, rd2;
  always @(posedge clk_i) begin
    if (rst_i) begin
      rv1 <= 1'b0;
      rv2 <= 1'b0;
    end else begin
      rv1 <= mem_req_o && mem_gnt_i;
      rd1 <= pat(mem_addr_o);
      rv2 <= rv1;
      rd2 <= rd1;
    end
  end
  assign mem_rvalid_i = (lat == 2) ? rv2 : rv1;
  assign mem_rdata_i  = (lat == 2) ? rd2 : rd1;

  int           cyc = 0;
  logic [63:0]  addr_log [$];
  logic [255:0] pop_data [$];
  logic         pop_last [$];
  int           pop_cyc  [$];
  int           done_cnt;
  int           done_cyc;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (mem_req_o && mem_gnt_i) addr_log.push_back(mem_addr_o);
      if (valid_o && ready_i) begin
        pop_data.push_back(data_o);
        pop_last.push_back(last_o);
        pop_cyc.push_back(cyc);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    cyc++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    addr_log.delete();
    pop_data.delete();
    pop_last.delete();
    pop_cyc.delete();
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_start(input logic [63:0] b, input logic [15:0] n);
    base_addr_i = b;
    num_words_i = n;
    start_i     = 1'b1;
    tick(1);
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      tick(1);
      k++;
    end
    chk("done_seen", 256'(done_cnt != 0), 256'(1));
  endtask

  task automatic check_stream(input string tag, input logic [63:0] b, input int n);
    logic [63:0] a;
    chk({tag, "_addr_cnt"}, 256'(addr_log.size()), 256'(n));
    chk({tag, "_pop_cnt"}, 256'(pop_data.size()), 256'(n));
    a = b;
    for (int i = 0; i < n && i < addr_log.size() && i < pop_data.size(); i++) begin
      chk({tag, "_addr"}, 256'(addr_log[i]), 256'(a));
      chk({tag, "_data"}, pop_data[i], pat(a));
      chk({tag, "_last"}, 256'(pop_last[i]), 256'(i == n - 1));
      a = a + 64'd32;
    end
  endtask

  initial begin
    int n;
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_words_i = '0;
    mem_gnt_i = 1'b1; ready_i = 1'b1;
    clear_logs();
    tick(3);
    rst_i = 1'b0;
    tick(1);
    chk("rst_busy", 256'(busy_o), 256'(0));
    chk("rst_done", 256'(done_o), 256'(0));
    chk("rst_req", 256'(mem_req_o), 256'(0));
    chk("rst_valid", 256'(valid_o), 256'(0));
    chk("rst_addr", 256'(mem_addr_o), 256'(0));
    chk("rst_we", 256'(mem_we_o), 256'(0));

    // basic 3-word transfer with latency 1
    clear_logs();
    do_start(64'h1000, 16'd3);
    chk("t1_busy", 256'(busy_o), 256'(1));
    n = 1;
    while (!valid_o && n < 20) begin
      tick(1);
      n++;
    end
    chk("t1_first_valid_lat", 256'(n), 256'(3));
    wait_done(50);
    check_stream("t1", 64'h1000, 3);
    if (pop_cyc.size() == 3) chk("t1_done_after_last", 256'(done_cyc), 256'(pop_cyc[2] + 1));
    tick(1);
    chk("t1_done_pulse", 256'(done_o), 256'(0));
    chk("t1_idle", 256'(busy_o), 256'(0));

    // back-pressure: credits cap grants at FifoDepth
    clear_logs();
    ready_i = 1'b0;
    do_start(64'h2000, 16'd8);
    tick(20);
    chk("t2_grants", 256'(addr_log.size()), 256'(4));
    chk("t2_req_low", 256'(mem_req_o), 256'(0));
    chk("t2_valid", 256'(valid_o), 256'(1));
    ready_i = 1'b1;
    wait_done(100);
    check_stream("t2", 64'h2000, 8);

    // grant withheld: request and address held
    clear_logs();
    mem_gnt_i = 1'b0;
    do_start(64'h1000, 16'd2);
    for (int i = 0; i < 5; i++) begin
      chk("t3_req_hold", 256'(mem_req_o), 256'(1));
      chk("t3_addr_hold", 256'(mem_addr_o), 256'(64'h1000));
      tick(1);
    end
    chk("t3_no_grant", 256'(addr_log.size()), 256'(0));
    mem_gnt_i = 1'b1;
    wait_done(50);
    check_stream("t3", 64'h1000, 2);

    // zero-length start
    clear_logs();
    tick(2);
    do_start(64'h5000, 16'd0);
    chk("t4_done", 256'(done_o), 256'(1));
    chk("t4_busy", 256'(busy_o), 256'(0));
    chk("t4_req", 256'(mem_req_o), 256'(0));
    tick(1);
    chk("t4_done_once", 256'(done_o), 256'(0));
    tick(3);
    chk("t4_no_reqs", 256'(addr_log.size()), 256'(0));

    // address wrap
    clear_logs();
    do_start(64'hFFFF_FFFF_FFFF_FFE0, 16'd2);
    wait_done(50);
    check_stream("t5", 64'hFFFF_FFFF_FFFF_FFE0, 2);

    // reset mid-FETCH with two outstanding (latency 2)
    clear_logs();
    lat = 2;
    do_start(64'h3000, 16'd4);
    tick(2);
    chk("t6_outstanding", 256'(addr_log.size()), 256'(2));
    chk("t6_busy_pre", 256'(busy_o), 256'(1));
    rst_i = 1'b1;
    tick(1);
    chk("t6_busy", 256'(busy_o), 256'(0));
    chk("t6_done", 256'(done_o), 256'(0));
    chk("t6_req", 256'(mem_req_o), 256'(0));
    chk("t6_valid", 256'(valid_o), 256'(0));
    chk("t6_last", 256'(last_o), 256'(0));
    chk("t6_addr", 256'(mem_addr_o), 256'(0));
    rst_i = 1'b0;
    lat = 1;
    tick(2);
    clear_logs();
    do_start(64'h4000, 16'd1);
    wait_done(50);
    check_stream("t6", 64'h4000, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
